// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: jump encodings, FSM states
// and a small alignment helper.
package pc_unit_pkg;

    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b10;
    localparam logic [1:0] JUMP_JALR = 2'b01;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_t;

    function automatic logic low_bits_set(input logic [1:0] addr_lsb);
        return |addr_lsb;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: jal / jalr / taken branch / sequential.
// PC_MISALIGN_TRAP_EN: report misaligned targets instead of forcing alignment.
module pc_next_sel #(
    parameter int PC_WIDTH = 16,
    parameter int XLEN     = 32
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] pc_plus4,
    input  logic [1:0]          jump,
    input  logic                branch,
    input  logic                flag,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     rs1,
    output logic [PC_WIDTH-1:0] target,
    output logic                misaligned
);
    import pc_unit_pkg::*;

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(2'b11);
    localparam logic [PC_WIDTH-1:0] BIT0_MASK  = ~PC_WIDTH'(1'b1);

    logic [PC_WIDTH-1:0] pc_rel_s;
    logic [PC_WIDTH-1:0] reg_rel_s;
    logic [PC_WIDTH-1:0] raw_s;

    // Sums are formed at XLEN width and then truncated to the PC width.
    assign pc_rel_s  = PC_WIDTH'(XLEN'(pc) + imm);
    assign reg_rel_s = PC_WIDTH'(rs1 + imm) & BIT0_MASK;

    // Jumps take priority over a taken branch; reserved encoding behaves as none.
    always_comb begin
        raw_s = pc_plus4;
        case (jump)
            JUMP_JAL:  raw_s = pc_rel_s;
            JUMP_JALR: raw_s = reg_rel_s;
            JUMP_NONE: begin
                if (branch && flag) begin
                    raw_s = pc_rel_s;
                end else begin
                    raw_s = pc_plus4;
                end
            end
            default: begin
                if (branch && flag) begin
                    raw_s = pc_rel_s;
                end else begin
                    raw_s = pc_plus4;
                end
            end
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign target     = raw_s;
    assign misaligned = low_bits_set(raw_s[1:0]);
`else
    assign target     = raw_s & ALIGN_MASK;
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/TRAP sequencing, PC register and retire counter.
// PC_MISALIGN_TRAP_EN: misaligned accepted targets enter TRAP until trap_ack.
module pc_unit #(
    parameter int                   PC_WIDTH     = 16,
    parameter int                   XLEN         = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          jump,
    input  logic                branch,
    input  logic                flag,
    input  logic [XLEN-1:0]     imm,
    input  logic [XLEN-1:0]     rs1,
    input  logic                stall,
    input  logic                pc_ready,
    input  logic                trap_ack,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                pc_valid,
    output logic                trap,
    output logic [PC_WIDTH-1:0] trap_addr,
    output logic [31:0]         retired
);
    import pc_unit_pkg::*;

    pc_state_t           state_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic                pc_valid_r;
    logic [31:0]         retired_r;
    logic [PC_WIDTH-1:0] target_s;
    logic                misaligned_s;
    logic                accept_s;

`ifdef PC_MISALIGN_TRAP_EN
    logic                trap_r;
    logic [PC_WIDTH-1:0] trap_addr_r;
`endif

    assign pc_plus4 = pc_r + PC_WIDTH'(3'd4);
    assign accept_s = pc_valid_r && pc_ready && !stall;

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH),
        .XLEN     (XLEN)
    ) u_next_sel (
        .pc         (pc_r),
        .pc_plus4   (pc_plus4),
        .jump       (jump),
        .branch     (branch),
        .flag       (flag),
        .imm        (imm),
        .rs1        (rs1),
        .target     (target_s),
        .misaligned (misaligned_s)
    );

    // Sequencing FSM with its registered outputs, PC and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            pc_r        <= RESET_VECTOR;
            pc_valid_r  <= 1'b0;
            retired_r   <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_r      <= 1'b0;
            trap_addr_r <= '0;
`endif
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r    <= ST_RUN;
                    pc_valid_r <= 1'b1;
                end
                ST_RUN: begin
                    if (accept_s) begin
                        if (misaligned_s) begin
                            // The offending fetch does not retire; pc keeps its address.
                            state_r     <= ST_TRAP;
                            pc_valid_r  <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                            trap_r      <= 1'b1;
                            trap_addr_r <= target_s;
`endif
                        end else begin
                            pc_r      <= target_s;
                            retired_r <= retired_r + 32'd1;
                        end
                    end
                end
                ST_TRAP: begin
                    if (trap_ack) begin
                        state_r    <= ST_RUN;
                        pc_valid_r <= 1'b1;
                        pc_r       <= RESET_VECTOR;
`ifdef PC_MISALIGN_TRAP_EN
                        trap_r     <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r    <= ST_BOOT;
                    pc_valid_r <= 1'b0;
                    pc_r       <= RESET_VECTOR;
                end
            endcase
        end
    end

    assign pc       = pc_r;
    assign pc_valid = pc_valid_r;
    assign retired  = retired_r;

`ifdef PC_MISALIGN_TRAP_EN
    assign trap      = trap_r;
    assign trap_addr = trap_addr_r;
`else
    assign trap      = 1'b0;
    assign trap_addr = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized bench for pc_unit against an arithmetic reference model.
// Honors PC_MISALIGN_TRAP_EN the same way as the design.
module tb_pc_unit;

    localparam int unsigned RV   = 32'h0000;
    localparam int unsigned MASK = 32'h0000_FFFF;

    logic        clk;
    logic        rst_n;
    logic [1:0]  jump;
    logic        branch;
    logic        flag;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        stall;
    logic        pc_ready;
    logic        trap_ack;
    logic [15:0] pc;
    logic [15:0] pc_plus4;
    logic        pc_valid;
    logic        trap;
    logic [15:0] trap_addr;
    logic [31:0] retired;

    int n_vec;
    int n_err;

    // Reference model state
    int unsigned m_pc;
    int unsigned m_ret;
    int unsigned m_trap_addr;
    bit          m_valid;
    bit          m_trap;
    bit          m_boot;

    pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .jump      (jump),
        .branch    (branch),
        .flag      (flag),
        .imm       (imm),
        .rs1       (rs1),
        .stall     (stall),
        .pc_ready  (pc_ready),
        .trap_ack  (trap_ack),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .pc_valid  (pc_valid),
        .trap      (trap),
        .trap_addr (trap_addr),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_ret = 0; m_trap_addr = 0;
        m_valid = 1'b0; m_trap = 1'b0; m_boot = 1'b1;
    endtask

    task automatic model_step(input logic [1:0] j, input logic br, input logic fl,
                              input int unsigned im, input int unsigned r1,
                              input logic st, input logic rdy, input logic ack);
        int unsigned t;
        if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b1;
        end else if (m_trap) begin
            if (ack) begin
                m_trap = 1'b0; m_valid = 1'b1; m_pc = RV;
            end
        end else if (rdy && !st) begin
            if (j == 2'b10)      t = m_pc + im;
            else if (j == 2'b01) t = (r1 + im) & ~32'd1;
            else if (br && fl)   t = m_pc + im;
            else                 t = m_pc + 4;
            t = t & MASK;
`ifdef PC_MISALIGN_TRAP_EN
            if ((t % 4) != 0) begin
                m_trap = 1'b1; m_valid = 1'b0; m_trap_addr = t;
            end else begin
                m_pc = t; m_ret = m_ret + 1;
            end
`else
            m_pc = t - (t % 4);
            m_ret = m_ret + 1;
`endif
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".pc"}, {16'd0, pc}, m_pc);
        check({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, m_valid});
        check({tag, ".retired"}, retired, m_ret);
        check({tag, ".trap"}, {31'd0, trap}, {31'd0, m_trap});
        if (m_trap) check({tag, ".trap_addr"}, {16'd0, trap_addr}, m_trap_addr);
    endtask

    // One clock: apply inputs mid-cycle, check pc_plus4, clock, then compare with the model.
    task automatic cycle(input string tag, input logic [1:0] j, input logic br, input logic fl,
                         input logic [31:0] im, input logic [31:0] r1,
                         input logic st, input logic rdy, input logic ack);
        jump = j; branch = br; flag = fl; imm = im; rs1 = r1;
        stall = st; pc_ready = rdy; trap_ack = ack;
        #1;
        check({tag, ".pc_plus4"}, {16'd0, pc_plus4}, (m_pc + 4) & MASK);
        @(posedge clk);
        #1;
        model_step(j, br, fl, im, r1, st, rdy, ack);
        check_state(tag);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; jump = 2'b00; branch = 1'b0; flag = 1'b0;
        imm = 32'd0; rs1 = 32'd0; stall = 1'b0; pc_ready = 1'b0; trap_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot.valid", {31'd0, pc_valid}, 32'd0);
        check("boot.pc", {16'd0, pc}, RV);

        cycle("boot_exit", 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("jal_34", 2'b10, 1'b0, 1'b0, 32'h34, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("jal_back", 2'b10, 1'b0, 1'b0, 32'hFFFF_FFDC, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("br_taken", 2'b00, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("jal_to_10", 2'b10, 1'b0, 1'b0, 32'h8, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("br_not_taken", 2'b00, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("jump_over_br", 2'b10, 1'b1, 1'b1, 32'h20, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("jalr", 2'b01, 1'b0, 1'b0, 32'h4, 32'h0101, 1'b0, 1'b1, 1'b0);
        cycle("jalr_fffc", 2'b01, 1'b0, 1'b0, 32'h0, 32'hFFFC, 1'b0, 1'b1, 1'b0);
        cycle("wrap", 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("stall", 2'b10, 1'b0, 1'b0, 32'h40, 32'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("not_ready", 2'b10, 1'b0, 1'b0, 32'h40, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle("ack_in_run", 2'b00, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1);
        cycle("rsvd_jump", 2'b11, 1'b0, 1'b0, 32'h80, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("jal_zero", 2'b01, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cycle("jal_odd", 2'b10, 1'b0, 1'b0, 32'h6, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("trap_hold", 2'b10, 1'b0, 1'b0, 32'h40, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("trap_hold2", 2'b00, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle("trap_ack", 2'b00, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r_imm;
            logic [1:0]  r_j;
            r_imm = {{20{$urandom_range(0, 1) == 1}}, 12'($urandom)};
            if ($urandom_range(0, 3) != 0) r_imm[1:0] = 2'b00;
            r_j = 2'($urandom);
            cycle("random", r_j, 1'($urandom), 1'($urandom), r_imm, $urandom,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 2) == 0));
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_state("async_reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_WIDTH, default 16, SHALL set the program-counter width in bits (legal 8..32).
REQ-002 Parameter XLEN, default 32, SHALL set the immediate and rs1 operand width.
REQ-003 Parameter RESET_VECTOR, default 0, SHALL set the first fetch address (PC_WIDTH bits, word aligned).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 jump  input  2  00 none, 10 jal, 01 jalr, 11 reserved (treated as none).
REQ-007 branch  input  1  conditional branch instruction.
REQ-008 flag  input  1  ALU zero flag; branch taken when branch=1 and flag=1.
REQ-009 imm  input  XLEN  sign-extended immediate of the current instruction.
REQ-010 rs1  input  XLEN  jalr base register value.
REQ-011 stall  input  1  hold the current PC.
REQ-012 pc_ready  input  1  instruction memory accepts pc.
REQ-013 trap_ack  input  1  clears a pending trap.
REQ-014 pc  output  PC_WIDTH  current fetch address.
REQ-015 pc_plus4  output  PC_WIDTH  pc+4, link value for jal/jalr.
REQ-016 pc_valid  output  1  pc is valid for fetch.
REQ-017 trap  output  1  misaligned-target trap pending.
REQ-018 trap_addr  output  PC_WIDTH  offending target address.
REQ-019 retired  output  32  count of accepted fetches.

Function
REQ-020 The FSM SHALL have states BOOT, RUN and TRAP; it SHALL enter BOOT on reset.
REQ-021 BOOT SHALL last exactly one cycle after rst_n deasserts, hold pc=RESET_VECTOR with pc_valid=0, then go to RUN.
REQ-022 In RUN, pc_valid SHALL be 1; the fetch SHALL be accepted when pc_valid=1, pc_ready=1 and stall=0.
REQ-023 On acceptance, the next pc SHALL be: jal -> pc+imm; jalr -> (rs1+imm) with bit 0 cleared; taken branch -> pc+imm; otherwise pc+4.
REQ-024 If both jump and a taken branch are present, jump SHALL take priority.
REQ-025 Without acceptance (stall=1 or pc_ready=0), pc SHALL be held and jump/branch/imm/rs1 SHALL be ignored.
REQ-026 Arithmetic SHALL be done in XLEN bits and truncated to PC_WIDTH; pc+4 SHALL wrap modulo 2^PC_WIDTH.
REQ-027 pc_plus4 SHALL be combinational pc+4 (same wrap rule) in every state.
REQ-028 retired SHALL increment by 1 per accepted fetch and wrap from 0xFFFFFFFF to 0.
REQ-029 In TRAP, pc_valid SHALL be 0 and pc SHALL hold the pre-trap instruction address.
REQ-030 In TRAP, trap_ack=1 SHALL return to RUN with pc=RESET_VECTOR and clear trap on the same edge.
REQ-031 A trap_ack arriving outside TRAP SHALL be ignored.

Reset
REQ-032 Asserting rst_n low SHALL immediately set pc=RESET_VECTOR, pc_valid=0, trap=0, trap_addr=0, retired=0 and state=BOOT, including mid-fetch or mid-trap.

Configuration
REQ-033 With PC_MISALIGN_TRAP_EN defined, an accepted target with bits[1:0]≠0 SHALL enter TRAP, set trap=1 and trap_addr=target, and not increment retired.
REQ-034 Without PC_MISALIGN_TRAP_EN, targets SHALL have bits[1:0] forced to 0, trap and trap_addr SHALL be tied 0, and TRAP SHALL be unreachable.

Structure
REQ-035 The shared package SHALL hold the jump encodings (JUMP_NONE, JUMP_JAL, JUMP_JALR) and the FSM state encodings.
REQ-036 The next-PC selection SHALL be one combinational sub-module, pc_next_sel; the FSM, the registers and the counter SHALL be in pc_unit.

Verification
REQ-037 Reset release -> one cycle pc=0x0000, pc_valid=0, then pc_valid=1 with pc=0x0000 and retired=0.
REQ-038 pc=0x0000, jump=10, imm=0x34, pc_ready=1 -> pc_plus4=0x0004 before the edge, pc=0x0034 and retired=1 after it.
REQ-039 pc=0x0010, branch=1, flag=1, imm=-8 -> pc=0x0008; the same with flag=0 -> pc=0x0014.
REQ-040 jump=01, rs1=0x0101, imm=0x4 -> pc=0x0104; pc=0xFFFC with no jump or branch -> pc=0x0000.
REQ-041 stall=1 for 3 cycles with jump=10 -> pc and retired unchanged; pc_ready=0 likewise.
REQ-042 jal imm=0x6 from 0x0000: with the macro, trap=1, trap_addr=0x0006 and pc_valid=0 until trap_ack, then pc=RESET_VECTOR; without the macro, pc=0x0004.
